xp_rr_arb: RTL
==============

XP_RR_ARB -- requirements
Module: xp_rr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requestors (≥2).
REQ-002 SHALL have localparam IDX_W = $clog2(NUM_REQ), meaning the encoded grant index width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port req_vec, input, NUM_REQ, meaning per-requestor request.
REQ-006 SHALL have port req_last, input, NUM_REQ, meaning the requestor's current beat is the last beat of its packet.
REQ-007 SHALL have port gnt_rdy, input, 1, meaning downstream accepts the offered grant this cycle.
REQ-008 SHALL have port gnt_vld, output, 1, meaning a grant is offered.
REQ-009 SHALL have port gnt_vec, output, NUM_REQ, meaning the one-hot winner, zero when gnt_vld=0.
REQ-010 SHALL have port gnt_idx, output, IDX_W, meaning the binary index of gnt_vec, zero when gnt_vld=0.

Function
REQ-011 SHALL hold a one-hot start pointer register start_ptr; priority search begins at start_ptr and wraps through bit NUM_REQ-1 to bit0.
REQ-012 SHALL implement states IDLE, WAIT (grant offered, not yet accepted) and LOCK (mid-packet), plus an owner register (one-hot).
REQ-013 In IDLE, gnt_vec SHALL be the round-robin winner of req_vec from start_ptr in the same cycle (zero latency); gnt_vld = |req_vec.
REQ-014 Accept SHALL be defined as gnt_vld & gnt_rdy.
REQ-015 IDLE, gnt_vld & !gnt_rdy: owner <= winner, next state WAIT.
REQ-016 In WAIT, gnt_vec SHALL equal owner regardless of newly arriving higher-priority requests; gnt_vld = |(req_vec & owner).
REQ-017 Accept with req_last[winner]=1 (from IDLE, WAIT or LOCK): start_ptr <= winner rotated left by one (bit NUM_REQ-1 wraps to bit0), next state IDLE.
REQ-018 Accept with req_last[winner]=0: owner <= winner, next state LOCK, start_ptr unchanged.
REQ-019 In LOCK, gnt_vec SHALL equal owner; gnt_vld = |(req_vec & owner); other requestors SHALL never be granted.
REQ-020 Owner deasserting request in LOCK: gnt_vld=0, remain LOCK (packet integrity).
REQ-021 Owner deasserting request in WAIT: return to IDLE, start_ptr unchanged.
REQ-022 req_vec=0 in IDLE: gnt_vld=0, gnt_vec=0, start_ptr and state unchanged.
REQ-023 gnt_vec SHALL be one-hot or zero in every cycle; a simulation assertion SHALL check this.

Reset
REQ-024 With rst_n=0 at a clock edge: start_ptr <= bit0 set ({..0,1}), state <= IDLE, owner <= 0.
REQ-025 While rst_n=0, gnt_vld, gnt_vec and gnt_idx SHALL be forced to 0.
REQ-026 Reset in WAIT or LOCK SHALL abandon the packet with no further grant to the old owner unless re-won in IDLE.

Structure
REQ-027 The state encoding (IDLE=2'd0, WAIT=2'd1, LOCK=2'd2) SHALL live in the shared xp package as localparams.
REQ-028 The IDLE winner search SHALL instantiate the existing xp_sel_bit_from_vec (VEC_WIDTH=NUM_REQ, startx=start_ptr).
REQ-029 The one-hot-to-binary conversion for gnt_idx SHALL be local combinational logic; no other sub-modules.

Verification (NUM_REQ=4)
REQ-030 Reset, req_vec=4'b1010, req_last=4'b1111, gnt_rdy=1 -> gnt_vec sequence 0010, 1000, 0010 on consecutive cycles; gnt_idx 1, 3, 1.
REQ-031 start_ptr=0001, req_vec=1100, gnt_rdy=0 for 3 cycles; cycle 2 add req bit0 -> gnt_vec stays 0100 all 3 cycles; then gnt_rdy=1 -> accepted 0100, next grant 1000.
REQ-032 req_vec=0011, req_last[0]=0 for 2 beats then 1, gnt_rdy=1 -> gnt_vec 0001 for 3 accepted beats, then 0010.
REQ-033 In LOCK with owner 0001, drop req bit0 for 2 cycles with req_vec=1110 -> gnt_vld=0, gnt_vec=0 both cycles; re-assert -> gnt_vec=0001.
REQ-034 rst_n=0 for one cycle while in LOCK -> next cycle state IDLE, start_ptr=0001, gnt_vld=0 during reset; with req_vec=0100 afterwards -> gnt_vec=0100.
REQ-035 req_vec=0 for 5 cycles -> gnt_vld=0, gnt_vec=0, start_ptr unchanged.

Source files
------------

// File: rtl/xp_pkg.sv
// Shared xp package: arbiter state encoding used by xp_rr_arb.
package xp_pkg;
    localparam logic [1:0] XP_ST_IDLE = 2'd0;
    localparam logic [1:0] XP_ST_WAIT = 2'd1;
    localparam logic [1:0] XP_ST_LOCK = 2'd2;
endpackage

// File: rtl/xp_sel_bit_from_vec.sv
// Picks the first set bit of vec at or above the one-hot position startx,
// wrapping from the top bit back to bit 0. Result is one-hot or zero.
module xp_sel_bit_from_vec #(
    parameter int VEC_WIDTH = 4
) (
    input  logic [VEC_WIDTH-1:0] vec,
    input  logic [VEC_WIDTH-1:0] startx,
    output logic [VEC_WIDTH-1:0] sel
);
    logic [2*VEC_WIDTH-1:0] dbl;
    logic [2*VEC_WIDTH-1:0] dbl_m;
    logic [2*VEC_WIDTH-1:0] hit;

    // Borrow from startx ripples up to the first set bit of the doubled vector,
    // so d & ~(d - s) isolates exactly that bit; the upper copy covers wrap-around.
    always_comb begin
        dbl   = {vec, vec};
        dbl_m = dbl - {{VEC_WIDTH{1'b0}}, startx};
        hit   = dbl & ~dbl_m;
        sel   = hit[VEC_WIDTH-1:0] | hit[2*VEC_WIDTH-1:VEC_WIDTH];
    end
endmodule

// File: rtl/xp_rr_arb.sv
// Round-robin packet arbiter: zero-latency grant in IDLE, grant held in WAIT
// until accepted, and locked to the owner across a multi-beat packet.
module xp_rr_arb
    import xp_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [NUM_REQ-1:0] req_last,
    input  logic               gnt_rdy,
    output logic               gnt_vld,
    output logic [NUM_REQ-1:0] gnt_vec,
    output logic [IDX_W-1:0]   gnt_idx
);
    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] start_ptr_q, start_ptr_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;

    logic [NUM_REQ-1:0] rr_sel;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] winner_rotl;
    logic               in_idle;
    logic               raw_vld;
    logic               accept;
    logic               is_last;

    xp_sel_bit_from_vec #(
        .VEC_WIDTH(NUM_REQ)
    ) u_sel (
        .vec   (req_vec),
        .startx(start_ptr_q),
        .sel   (rr_sel)
    );

    always_comb begin
        in_idle     = (state_q == XP_ST_IDLE);
        winner      = in_idle ? rr_sel : owner_q;
        raw_vld     = in_idle ? (|req_vec) : (|(req_vec & owner_q));
        gnt_vld     = rst_n & raw_vld;
        gnt_vec     = gnt_vld ? winner : '0;
        accept      = gnt_vld & gnt_rdy;
        is_last     = |(req_last & winner);
        winner_rotl = {winner[NUM_REQ-2:0], winner[NUM_REQ-1]};
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                gnt_idx = gnt_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ptr_d = start_ptr_q;
        owner_d     = owner_q;
        // An accepted last beat always ends the packet, whatever state we are in.
        if (accept && is_last) begin
            state_d     = XP_ST_IDLE;
            start_ptr_d = winner_rotl;
            owner_d     = '0;
        end else if (accept) begin
            state_d = XP_ST_LOCK;
            owner_d = winner;
        end else begin
            case (state_q)
                XP_ST_IDLE: begin
                    if (gnt_vld) begin
                        state_d = XP_ST_WAIT;
                        owner_d = winner;
                    end
                end
                XP_ST_WAIT: begin
                    if (!gnt_vld) begin
                        state_d = XP_ST_IDLE;
                        owner_d = '0;
                    end
                end
                XP_ST_LOCK: begin
                    // Owner gaps keep the lock so no other packet can interleave.
                    state_d = XP_ST_LOCK;
                end
                default: begin
                    state_d = XP_ST_IDLE;
                    owner_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= XP_ST_IDLE;
            start_ptr_q <= {{(NUM_REQ-1){1'b0}}, 1'b1};
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_ptr_q <= start_ptr_d;
            owner_q     <= owner_d;
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_vec));
endmodule
